// File: rtl/busca_instrucao.sv
// -----------------------------------------------------------------------------
// busca_instrucao -- instruction-fetch stage ahead of the main control decoder.
//
// Holds the PC and reads one instruction word at a time from instruction
// memory over a req/ack handshake. The returned word is registered and shown
// to the decoder and datapath, together with its opcode. When the datapath
// finishes the instruction, the next PC is chosen from the decoder's
// Branch/Jump outputs. A misaligned target stops the stage in a sticky error
// state, which only reset clears.
//
// Ports:
//   iCLK, iRST_n        clock (rising edge); asynchronous active-low reset
//   iHabilita           allows a new fetch to start
//   iBranch, iJump      decoder outputs for the current instruction
//   iJalr               current instruction is JALR
//   iTomado             branch condition from the ALU compare
//   iImm, iRegBase      sign-extended immediate; rs1 value (JALR base)
//   iAvanca             datapath done with the current instruction
//   oMemReq, oMemEnd    memory read request and word address (current PC)
//   iMemAck, iMemDado   memory data valid this cycle, and the read data
//   oInstr, oOpcode     registered instruction and its bits [6:0]
//   oPC, oPC4           PC of oInstr and that PC + 4 (link value)
//   oValida             oInstr may be executed
//   oErroAlinh          sticky misaligned-target flag
// -----------------------------------------------------------------------------
module busca_instrucao #(
  parameter logic [31:0] PC_INICIAL = 32'h0040_0000,
  parameter int          LARGURA    = 32
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iHabilita,
  input  logic               iBranch,
  input  logic               iJump,
  input  logic               iJalr,
  input  logic               iTomado,
  input  logic [LARGURA-1:0] iImm,
  input  logic [LARGURA-1:0] iRegBase,
  input  logic               iAvanca,
  output logic               oMemReq,
  output logic [LARGURA-1:0] oMemEnd,
  input  logic               iMemAck,
  input  logic [LARGURA-1:0] iMemDado,
  output logic [LARGURA-1:0] oInstr,
  output logic [6:0]         oOpcode,
  output logic [LARGURA-1:0] oPC,
  output logic [LARGURA-1:0] oPC4,
  output logic               oValida,
  output logic               oErroAlinh
);

  typedef enum logic [1:0] {
    BUSCA  = 2'd0,  // idle; the request follows iHabilita
    ESPERA = 2'd1,  // request issued, waiting for the ack
    PRONTA = 2'd2,  // instruction valid, waiting for iAvanca
    ERRO   = 2'd3   // misaligned target; only reset leaves this state
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] pc_q, pc_d;
  logic [LARGURA-1:0] instr_q, instr_d;

  logic [LARGURA-1:0] soma_jalr;
  logic [LARGURA-1:0] pc_prox;
  logic               desalinhado;
  logic               req;

  // Next-PC selection in priority order. All sums wrap modulo 2^32.
  always_comb begin
    soma_jalr = iRegBase + iImm;
    if (iJump && iJalr) begin
      pc_prox = {soma_jalr[LARGURA-1:1], 1'b0};
    end else if (iJump || (iBranch && iTomado)) begin
      pc_prox = pc_q + iImm;
    end else begin
      pc_prox = pc_q + LARGURA'(4);
    end
    // Bit 0 can only be set on a PC+imm target, because JALR clears it.
    // Either low bit set means the target is not word aligned.
    desalinhado = |pc_prox[1:0];
  end

  // NOTE: every variable written in this block gets a default first, so
  // paths that do not assign it cannot infer a latch.
  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    req      = 1'b0;
    unique case (estado_q)
      BUSCA: begin
        if (iHabilita) begin
          req = 1'b1;
          if (iMemAck) begin
            instr_d  = iMemDado;
            estado_d = PRONTA;
          end else begin
            estado_d = ESPERA;
          end
        end
      end
      ESPERA: begin
        // An issued request is never withdrawn, even if iHabilita drops.
        req = 1'b1;
        if (iMemAck) begin
          instr_d  = iMemDado;
          estado_d = PRONTA;
        end
      end
      PRONTA: begin
        if (iAvanca) begin
          if (desalinhado) begin
            // Keep the PC so oPC still points at the faulting instruction.
            estado_d = ERRO;
          end else begin
            pc_d     = pc_prox;
            estado_d = BUSCA;
          end
        end
      end
      ERRO: begin
        estado_d = ERRO;
      end
      default: begin
        estado_d = BUSCA;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the clock edge, whatever the statement order.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      estado_q <= BUSCA;
      pc_q     <= PC_INICIAL;
      instr_q  <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
    end
  end

  // NOTE: the request is gated by iRST_n directly. While reset is held, the
  // state already reads BUSCA, and iHabilita alone must not raise a request.
  assign oMemReq    = req && iRST_n;
  assign oMemEnd    = pc_q;
  assign oInstr     = instr_q;
  assign oOpcode    = instr_q[6:0];
  assign oPC        = pc_q;
  assign oPC4       = pc_q + LARGURA'(4);
  assign oValida    = (estado_q == PRONTA);
  assign oErroAlinh = (estado_q == ERRO);

endmodule

// File: tb/tb_busca_instrucao.sv
// -----------------------------------------------------------------------------
// tb_busca_instrucao -- directed, self-checking bench for busca_instrucao.
// Expected fetch addresses are queued when a fetch is set up. Each one is
// popped and compared when the handshake completes.
// A second instance starts at 32'hFFFF_FFFC to exercise PC wrap-around.
// -----------------------------------------------------------------------------
module tb_busca_instrucao;

  logic        iCLK;
  logic        iRST_n;
  logic        hab, br, jmp, jr, tom, avan, ack;
  logic [31:0] imm, base, mdado;
  logic        oMemReq, oValida, oErroAlinh;
  logic [31:0] oMemEnd, oInstr, oPC, oPC4;
  logic [6:0]  oOpcode;

  // Wrap-around instance: separate handshake inputs, no control flow.
  logic        w_hab, w_ack, w_avan;
  logic [31:0] w_dado;
  logic        w_req, w_valida, w_erro;
  logic [31:0] w_end, w_instr, w_pc, w_pc4;
  logic [6:0]  w_opcode;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_end[$];
  logic [31:0] descarte;

  busca_instrucao dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iHabilita(hab),
    .iBranch(br), .iJump(jmp), .iJalr(jr), .iTomado(tom),
    .iImm(imm), .iRegBase(base), .iAvanca(avan),
    .oMemReq(oMemReq), .oMemEnd(oMemEnd), .iMemAck(ack), .iMemDado(mdado),
    .oInstr(oInstr), .oOpcode(oOpcode), .oPC(oPC), .oPC4(oPC4),
    .oValida(oValida), .oErroAlinh(oErroAlinh)
  );

  busca_instrucao #(.PC_INICIAL(32'hFFFF_FFFC)) dut_wrap (
    .iCLK(iCLK), .iRST_n(iRST_n), .iHabilita(w_hab),
    .iBranch(1'b0), .iJump(1'b0), .iJalr(1'b0), .iTomado(1'b0),
    .iImm(32'h0), .iRegBase(32'h0), .iAvanca(w_avan),
    .oMemReq(w_req), .oMemEnd(w_end), .iMemAck(w_ack), .iMemDado(w_dado),
    .oInstr(w_instr), .oOpcode(w_opcode), .oPC(w_pc), .oPC4(w_pc4),
    .oValida(w_valida), .oErroAlinh(w_erro)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request must be high and the address must match the scoreboard head.
  task automatic req_chk(input string tag, input bit pop);
    check({tag, "_req"}, 32'(oMemReq), 32'd1);
    n_chk++;
    assert (exp_end.size() != 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed oMemEnd=%h expected=<empty scoreboard>", tag, oMemEnd);
    end
    if (exp_end.size() != 0) begin
      check({tag, "_end"}, oMemEnd, exp_end[0]);
      if (pop) descarte = exp_end.pop_front();
    end
  endtask

  // Fetch with a same-cycle ack, starting in BUSCA.
  // The task returns with the stage in PRONTA.
  task automatic busca(input string tag, input logic [31:0] end_esp, input logic [31:0] dado);
    hab = 1'b1; ack = 1'b1; mdado = dado;
    exp_end.push_back(end_esp);
    #1;
    req_chk(tag, 1'b1);
    @(posedge iCLK); #1;
    hab = 1'b0; ack = 1'b0;
    #1;
    check({tag, "_valida"}, 32'(oValida), 32'd1);
    check({tag, "_pc"}, oPC, end_esp);
    check({tag, "_instr"}, oInstr, dado);
  endtask

  // One iAvanca cycle with the given decoder/ALU inputs.
  task automatic avanca(input logic b, input logic t, input logic j, input logic r,
                        input logic [31:0] im, input logic [31:0] bs);
    br = b; tom = t; jmp = j; jr = r; imm = im; base = bs; avan = 1'b1;
    @(posedge iCLK); #1;
    br = 1'b0; tom = 1'b0; jmp = 1'b0; jr = 1'b0; imm = '0; base = '0; avan = 1'b0;
  endtask

  initial begin
    iRST_n = 1'b0;
    hab = 1'b1; ack = 1'b0; br = 1'b0; jmp = 1'b0; jr = 1'b0; tom = 1'b0;
    avan = 1'b0; imm = '0; base = '0; mdado = '0;
    w_hab = 1'b0; w_ack = 1'b0; w_avan = 1'b0; w_dado = '0;

    // Reset state. iHabilita is high, but no request may appear.
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_req",    32'(oMemReq),    32'd0);
    check("rst_valida", 32'(oValida),    32'd0);
    check("rst_erro",   32'(oErroAlinh), 32'd0);
    check("rst_instr",  oInstr,          32'd0);
    check("rst_opcode", 32'(oOpcode),    32'd0);
    check("rst_end",    oMemEnd,         32'h0040_0000);
    iRST_n = 1'b1;

    // First fetch with a same-cycle ack, then a sequential advance.
    busca("t1", 32'h0040_0000, 32'h0000_0013);
    check("t1_opcode", 32'(oOpcode), 32'h13);
    check("t1_pc4",    oPC4,         32'h0040_0004);
    check("t1_noreq",  32'(oMemReq), 32'd0);
    avanca(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_valida_drop", 32'(oValida), 32'd0);
    check("t1_next_end",    oMemEnd,      32'h0040_0004);

    // Ack delayed 3 cycles. iHabilita drops during ESPERA.
    hab = 1'b1; ack = 1'b0;
    exp_end.push_back(32'h0040_0004);
    #1; req_chk("t2_c0", 1'b0);
    @(posedge iCLK); #1; hab = 1'b0;
    #1; req_chk("t2_c1", 1'b0);
    check("t2_c1_valida", 32'(oValida), 32'd0);
    @(posedge iCLK); #1;
    req_chk("t2_c2", 1'b0);
    @(posedge iCLK); #1; ack = 1'b1; mdado = 32'h0000_0033;
    #1; req_chk("t2_c3", 1'b1);
    check("t2_c3_valida", 32'(oValida), 32'd0);
    @(posedge iCLK); #1; ack = 1'b0;
    #1;
    check("t2_valida", 32'(oValida), 32'd1);
    check("t2_opcode", 32'(oOpcode), 32'h33);

    // Branches around PC 0x0040_0010.
    avanca(1'b0, 1'b0, 1'b1, 1'b0, 32'd12, 32'h0);
    busca("t3a", 32'h0040_0010, 32'h0000_0063);
    avanca(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    busca("t3b", 32'h0040_0008, 32'h0000_0063);
    avanca(1'b1, 1'b1, 1'b0, 1'b0, 32'd8, 32'h0);
    busca("t3c", 32'h0040_0010, 32'h0000_0063);
    avanca(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    busca("t3d", 32'h0040_0014, 32'h0000_0063);

    // JALR clears bit 0 of the target. JAL with imm 6 lands misaligned.
    avanca(1'b0, 1'b0, 1'b1, 1'b1, 32'd3, 32'h0040_0101);
    busca("t4a", 32'h0040_0104, 32'h0000_0067);
    check("t4a_pc4", oPC4, 32'h0040_0108);
    avanca(1'b0, 1'b0, 1'b1, 1'b0, 32'd6, 32'h0);
    check("t4_erro",   32'(oErroAlinh), 32'd1);
    check("t4_valida", 32'(oValida),    32'd0);
    check("t4_pc",     oPC,             32'h0040_0104);
    hab = 1'b1; ack = 1'b1; avan = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t4_noreq%0d", i), 32'(oMemReq), 32'd0);
      check($sformatf("t4_sticky%0d", i), 32'(oErroAlinh), 32'd1);
      @(posedge iCLK); #1;
    end
    hab = 1'b0; ack = 1'b0; avan = 1'b0;

    // PC wraps from 0xFFFF_FFFC to 0 without an error.
    w_hab = 1'b1; w_ack = 1'b1; w_dado = 32'h0000_0013;
    #1;
    check("t5_req", 32'(w_req), 32'd1);
    check("t5_end", w_end,      32'hFFFF_FFFC);
    @(posedge iCLK); #1; w_hab = 1'b0; w_ack = 1'b0;
    #1;
    check("t5_valida", 32'(w_valida), 32'd1);
    w_avan = 1'b1;
    @(posedge iCLK); #1; w_avan = 1'b0;
    #1;
    check("t5_wrap_end", w_end,        32'h0000_0000);
    check("t5_wrap_err", 32'(w_erro),  32'd0);

    // Reset leaves ERRO. Then reset again in the middle of ESPERA.
    iRST_n = 1'b0;
    #1;
    check("t6_rst_erro", 32'(oErroAlinh), 32'd0);
    @(posedge iCLK); #1; iRST_n = 1'b1;
    busca("t6a", 32'h0040_0000, 32'h0000_0093);
    avanca(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    hab = 1'b1; ack = 1'b0;
    exp_end.push_back(32'h0040_0004);
    #1; req_chk("t6b", 1'b0);
    @(posedge iCLK); #1;
    req_chk("t6c", 1'b0);
    iRST_n = 1'b0;
    #1;
    check("t6_rst_req",    32'(oMemReq), 32'd0);
    check("t6_rst_end",    oMemEnd,      32'h0040_0000);
    check("t6_rst_instr",  oInstr,       32'd0);
    check("t6_rst_valida", 32'(oValida), 32'd0);
    // The fetch aborted by reset never completes.
    descarte = exp_end.pop_front();
    @(posedge iCLK); #1; iRST_n = 1'b1;
    busca("t6d", 32'h0040_0000, 32'h0000_006F);
    check("t6d_opcode", 32'(oOpcode), 32'h6F);

    check("sb_empty", 32'(exp_end.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction-fetch stage sitting directly upstream of the main control decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Registers the returned instruction and presents it, plus its 7-bit opcode, to the decoder and datapath.
- Computes the next PC from the decoder's Branch/Jump outputs.

Parameters:
PC_INICIAL, 32'h0040_0000, PC value loaded on reset
LARGURA, 32, address/data width in bits (only 32 is supported)

Ports:
iCLK  in  1  clock, rising edge
iRST_n  in  1  asynchronous active-low reset
iHabilita  in  1  allows a new fetch to start
iBranch  in  1  Branch output of the decoder for the current instruction
iJump  in  1  Jump output of the decoder for the current instruction
iJalr  in  1  current instruction is JALR (opcode 1100111)
iTomado  in  1  branch condition true, from the ALU compare
iImm  in  32  sign-extended immediate of the current instruction
iRegBase  in  32  rs1 value (JALR base)
iAvanca  in  1  datapath finished the current instruction; advance the PC
oMemReq  out  1  instruction-memory read request
oMemEnd  out  32  read address (current PC)
iMemAck  in  1  memory data valid this cycle
iMemDado  in  32  memory read data
oInstr  out  32  registered instruction
oOpcode  out  7  oInstr[6:0]
oPC  out  32  PC of oInstr
oPC4  out  32  oPC+4 (JAL/JALR link value)
oValida  out  1  oInstr is valid for execution
oErroAlinh  out  1  sticky misaligned-target flag

Behaviour:
- FSM states: BUSCA, ESPERA, PRONTA, ERRO.
- Reset (async, immediate on iRST_n low):
  - state=BUSCA, PC=PC_INICIAL.
  - oInstr=0, so oOpcode=0 and the decoder falls into its all-zero default.
  - oValida=0, oMemReq=0, oErroAlinh=0.
- BUSCA:
  - oMemReq = iHabilita (combinational from state), oMemEnd=PC.
  - If iHabilita=0: stay in BUSCA.
  - If iHabilita=1 and iMemAck=0: go to ESPERA.
  - If iHabilita=1 and iMemAck=1: capture iMemDado into oInstr and go to PRONTA (same-cycle ack).
- ESPERA:
  - oMemReq=1 regardless of iHabilita; the request is never aborted.
  - oMemEnd is stable.
  - On iMemAck=1: capture into oInstr and go to PRONTA.
- PRONTA:
  - oValida=1, oMemReq=0.
  - oInstr and oPC are held stable until iAvanca.
  - On iAvanca=1: PC <= next PC, oValida drops the next cycle, go to BUSCA.
  - If the next PC is misaligned: PC is not updated; go to ERRO instead.
- iAvanca is ignored in every state except PRONTA.
- iMemAck is ignored outside BUSCA-with-request and ESPERA.
- Next PC, in priority order, all arithmetic modulo 2^32:
  - iJump & iJalr: (iRegBase+iImm) & ~1
  - iJump: PC+iImm
  - iBranch & iTomado: PC+iImm
  - otherwise: PC+4
  - PC+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000; this is not an error.
- Misalignment: next PC bit1 = 1, checked after the JALR bit0 clear.
  - A PC+iImm result with bit0=1 also counts as misaligned.
- ERRO:
  - oErroAlinh=1, oValida=0, oMemReq=0.
  - oPC holds the faulting instruction's PC.
  - Left only by reset.
- oPC4 = oPC+4, combinational.
- Minimum latency: 1 cycle from request to oValida (ack in the request cycle). The throughput bound is 2 cycles per instruction.

Test Plan:
- Reset release, iHabilita=1, iMemAck tied 1, memory returns 32'h0000_0013 -> first request at 0x0040_0000. oValida=1 the next cycle with oOpcode=7'h13. After iAvanca, oMemEnd=0x0040_0004.
- Ack delayed 3 cycles -> oMemReq stays high and oMemEnd stays stable for all 4 cycles. oValida rises exactly 1 cycle after the ack. Dropping iHabilita during ESPERA does not drop oMemReq.
- PC=0x0040_0010, iBranch=1, iTomado=1, iImm=-8 -> next fetch at 0x0040_0008. Same stimulus with iTomado=0 -> fetch at 0x0040_0014.
- JALR with iRegBase=0x0040_0101, iImm=3 -> fetch at 0x0040_0104 and oPC4=oPC+4. JAL with iImm=6 -> ERRO, oErroAlinh=1, no further oMemReq.
- PC_INICIAL=32'hFFFF_FFFC, sequential advance -> next oMemEnd=0, no error.
- iRST_n pulsed low mid-ESPERA -> oMemReq drops the same cycle, PC=PC_INICIAL, oInstr=0, and fetch restarts cleanly.
